// File: rtl/vga_board_renderer_if.sv
// Board-state and video signals between the game controller, the renderer and the VGA DAC.
// The master drives the board state and the slave (the renderer) drives the video outputs.
interface vga_board_renderer_if #(
    parameter int ROWS = 6,
    parameter int COLS = 7
);
    logic                   turn;
    logic [ROWS*COLS-1:0]   player1;
    logic [ROWS*COLS-1:0]   player2;
    logic [ROWS*COLS-1:0]   win_mask;
    logic [COLS-1:0]        put_line;
    logic                   hsync;
    logic                   vsync;
    logic [3:0]             red;
    logic [3:0]             green;
    logic [3:0]             blue;
    logic                   frame_start;

    modport master (
        output turn, player1, player2, win_mask, put_line,
        input  hsync, vsync, red, green, blue, frame_start
    );

    modport slave (
        input  turn, player1, player2, win_mask, put_line,
        output hsync, vsync, red, green, blue, frame_start
    );
endinterface

// File: rtl/vga_board_renderer.sv
// VGA timing generator and Score4 board renderer: per-frame board snapshot, blinking win cells,
// and a two-stage pixel pipeline so that sync and colour leave the block together.
module vga_board_renderer #(
    parameter int DIV          = 2,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 32,
    parameter int ROWS         = 6,
    parameter int COLS         = 7,
    parameter int CELL         = 30,
    parameter int PITCH        = 60,
    parameter int X0           = 60,
    parameter int Y0           = 30,
    parameter int PUT_H        = 20,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                clk,
    input  logic                rst,
    vga_board_renderer_if.slave bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int N       = ROWS * COLS;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DW-1:0] div_cnt_reg;
    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;
    logic          pe;
    logic          h_last;
    logic          v_last;
    logic          snap;

    assign pe     = (div_cnt_reg == DW'(DIV - 1));
    assign h_last = (h_cnt_reg == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt_reg == VW'(V_TOTAL - 1));
    assign snap   = pe && h_last && v_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_reg <= '0;
            h_cnt_reg   <= '0;
            v_cnt_reg   <= '0;
        end else begin
            div_cnt_reg <= pe ? '0 : div_cnt_reg + 1'b1;
            if (pe) begin
                if (h_last) begin
                    h_cnt_reg <= '0;
                    v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
                end else begin
                    h_cnt_reg <= h_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Shadow copy of the board, taken on the very last pixel so a frame never mixes two states.
    logic [N-1:0]    p1_sh_reg;
    logic [N-1:0]    p2_sh_reg;
    logic [N-1:0]    win_sh_reg;
    logic [COLS-1:0] put_sh_reg;
    logic            turn_sh_reg;
    logic [FW-1:0]   frame_cnt_reg;
    logic            blink_reg;
    logic            frame_start_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            p1_sh_reg       <= '0;
            p2_sh_reg       <= '0;
            win_sh_reg      <= '0;
            put_sh_reg      <= '0;
            turn_sh_reg     <= 1'b0;
            frame_cnt_reg   <= '0;
            blink_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= snap;
            if (snap) begin
                p1_sh_reg   <= bus.player1;
                p2_sh_reg   <= bus.player2;
                win_sh_reg  <= bus.win_mask;
                put_sh_reg  <= bus.put_line;
                turn_sh_reg <= bus.turn;
                if (frame_cnt_reg == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt_reg <= '0;
                    blink_reg     <= ~blink_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Stage 1 decode; 32-bit compares so geometry past the frame simply never matches.
    logic [31:0]     h_ext;
    logic [31:0]     v_ext;
    logic [COLS-1:0] col_dec;
    logic [ROWS-1:0] row_dec;
    logic            put_dec;
    logic            act_dec;
    logic            hs_dec;
    logic            vs_dec;

    assign h_ext = {{(32-HW){1'b0}}, h_cnt_reg};
    assign v_ext = {{(32-VW){1'b0}}, v_cnt_reg};

    genvar gi;
    for (gi = 0; gi < COLS; gi++) begin : g_col
        localparam int unsigned XL = X0 + gi * PITCH;
        // Leftmost screen column is the MSB board column.
        assign col_dec[COLS-1-gi] = (h_ext >= XL) && (h_ext < XL + CELL);
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_row
        localparam int unsigned YL = Y0 + gi * PITCH;
        assign row_dec[gi] = (v_ext >= YL) && (v_ext < YL + CELL);
    end

    assign put_dec = (v_ext >= Y0 + ROWS * PITCH) && (v_ext < Y0 + ROWS * PITCH + PUT_H);
    assign act_dec = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
    assign hs_dec  = (h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC);
    assign vs_dec  = (v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC);

    // Sync is carried as an "in pulse" flag so the cleared pipeline drives an idle (high) line.
    logic [COLS-1:0] col1_reg;
    logic [ROWS-1:0] row1_reg;
    logic            put1_reg;
    logic            act1_reg;
    logic            hs1_reg;
    logic            vs1_reg;
    logic [11:0]     rgb_reg;
    logic [11:0]     rgb_next;
    logic            hs2_reg;
    logic            vs2_reg;

    logic [N-1:0] cell_oh;
    for (gi = 0; gi < N; gi++) begin : g_cell
        assign cell_oh[gi] = row1_reg[gi / COLS] & col1_reg[gi % COLS];
    end

    logic cell_any;
    logic p1_hit;
    logic p2_hit;
    logic win_hit;
    logic put_hit;

    assign cell_any = |cell_oh;
    assign p1_hit   = |(cell_oh & p1_sh_reg);
    assign p2_hit   = |(cell_oh & p2_sh_reg);
    assign win_hit  = |(cell_oh & win_sh_reg);
    assign put_hit  = put1_reg && |(col1_reg & put_sh_reg);

    always_comb begin
        rgb_next = 12'h000;
        if (act1_reg) begin
            if (cell_any) begin
                if (win_hit && blink_reg) rgb_next = 12'hFFF;
                else if (p1_hit)          rgb_next = 12'hF10;
                else if (p2_hit)          rgb_next = 12'h0F3;
                else                      rgb_next = 12'h222;
            end else if (put_hit) begin
                rgb_next = turn_sh_reg ? 12'h0F3 : 12'hF01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col1_reg <= '0;
            row1_reg <= '0;
            put1_reg <= 1'b0;
            act1_reg <= 1'b0;
            hs1_reg  <= 1'b0;
            vs1_reg  <= 1'b0;
            rgb_reg  <= '0;
            hs2_reg  <= 1'b0;
            vs2_reg  <= 1'b0;
        end else if (pe) begin
            col1_reg <= col_dec;
            row1_reg <= row_dec;
            put1_reg <= put_dec;
            act1_reg <= act_dec;
            hs1_reg  <= hs_dec;
            vs1_reg  <= vs_dec;
            rgb_reg  <= rgb_next;
            hs2_reg  <= hs1_reg;
            vs2_reg  <= vs1_reg;
        end
    end

    assign bus.hsync       = ~hs2_reg;
    assign bus.vsync       = ~vs2_reg;
    assign bus.red         = rgb_reg[11:8];
    assign bus.green       = rgb_reg[7:4];
    assign bus.blue        = rgb_reg[3:0];
    assign bus.frame_start = frame_start_reg;
endmodule

// File: tb/tb_vga_board_renderer.sv
// Randomised board stimulus against a pixel-position reference model of a compact VGA geometry,
// including a reset in the middle of a blink phase.
module tb_vga_board_renderer;
    localparam int DIV = 2;
    localparam int H_ACTIVE = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
    localparam int V_ACTIVE = 30, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int ROWS = 3, COLS = 7, CELL = 4, PITCH = 6, X0 = 6, Y0 = 3, PUT_H = 3;
    localparam int BLINK_FRAMES = 2;
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int T = HT * VT;
    localparam int FT = T * DIV;
    localparam int N = ROWS * COLS;
    localparam int MAXF = 16;
    localparam int RST_AT = 6 * FT + 1500;
    localparam int RST_LEN = 5;
    localparam int TOTAL = 12 * FT + 2000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_board_renderer_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    vga_board_renderer #(
        .DIV(DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .ROWS(ROWS), .COLS(COLS), .CELL(CELL), .PITCH(PITCH), .X0(X0), .Y0(Y0),
        .PUT_H(PUT_H), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Board state as seen at each snapshot; index f is what frame f shows (index 0 = after reset).
    logic [N-1:0]    s_p1   [MAXF];
    logic [N-1:0]    s_p2   [MAXF];
    logic [N-1:0]    s_win  [MAXF];
    logic [COLS-1:0] s_put  [MAXF];
    logic            s_turn [MAXF];

    int n_checks = 0;
    int n_pass = 0;
    int k = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at clk %0d: got %h, expected %h", tag, k, got, exp);
    endtask

    function automatic logic [11:0] colour(int h, int v, int f);
        int r = -1;
        int c = -1;
        int idx;
        bit put;
        bit bl;
        if (h >= H_ACTIVE || v >= V_ACTIVE) return 12'h000;
        for (int i = 0; i < COLS; i++)
            if (h >= X0 + i * PITCH && h <= X0 + i * PITCH + CELL - 1) c = COLS - 1 - i;
        for (int i = 0; i < ROWS; i++)
            if (v >= Y0 + i * PITCH && v <= Y0 + i * PITCH + CELL - 1) r = i;
        put = (v >= Y0 + ROWS * PITCH) && (v <= Y0 + ROWS * PITCH + PUT_H - 1);
        bl = ((f / BLINK_FRAMES) % 2) == 1;
        if (c < 0) return 12'h000;
        if (r >= 0) begin
            idx = r * COLS + c;
            if (s_win[f][idx] && bl) return 12'hFFF;
            if (s_p1[f][idx]) return 12'hF10;
            if (s_p2[f][idx]) return 12'h0F3;
            return 12'h222;
        end
        if (put && s_put[f][c]) return s_turn[f] ? 12'h0F3 : 12'hF01;
        return 12'h000;
    endfunction

    // kk = clock edges since reset release; output shows the pixel two pixel-periods back.
    function automatic logic [13:0] model(int kk);
        int n, q, f, p, h, v;
        logic hs, vs;
        n = kk / DIV;
        if (n < 2) return {2'b11, 12'h000};
        q = n - 2;
        f = q / T;
        p = q % T;
        h = p % HT;
        v = p / HT;
        hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
        vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
        return {hs, vs, colour(h, v, f)};
    endfunction

    task automatic randomize_board();
        int sel;
        bus.player1 = N'($urandom);
        bus.player2 = N'($urandom);
        bus.win_mask = N'($urandom);
        sel = $urandom_range(0, COLS);
        bus.put_line = (sel == COLS) ? '0 : (COLS'(1) << sel);
        bus.turn = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [13:0] e;
        logic fs_exp;
        int idx;
        bus.turn = 1'b0;
        bus.player1 = '0;
        bus.player2 = '0;
        bus.win_mask = '0;
        bus.put_line = '0;
        for (int i = 0; i < MAXF; i++) begin
            s_p1[i] = '0;
            s_p2[i] = '0;
            s_win[i] = '0;
            s_put[i] = '0;
            s_turn[i] = 1'b0;
        end
        for (int cyc = 0; cyc < TOTAL; cyc++) begin
            @(negedge clk);
            if (rst) k++;
            else k = 0;
            e = model(k);
            fs_exp = (k > 0) && (k % FT == 0);
            check("sync", {30'd0, bus.hsync, bus.vsync}, {30'd0, e[13:12]});
            check("rgb", {20'd0, bus.red, bus.green, bus.blue}, {20'd0, e[11:0]});
            check("frame_start", {31'd0, bus.frame_start}, {31'd0, fs_exp});
            if (fs_exp)
                $display("frame %0d snapshot: p1=%h p2=%h win=%h put=%h turn=%0d",
                         k / FT, s_p1[k / FT], s_p2[k / FT], s_win[k / FT],
                         s_put[k / FT], s_turn[k / FT]);
            rst = !(cyc < 3 || (cyc >= RST_AT && cyc < RST_AT + RST_LEN));
            if (rst && $urandom_range(0, 399) == 0) randomize_board();
            if (rst && ((k + 1) % FT == 0)) begin
                idx = (k + 1) / FT;
                s_p1[idx] = bus.player1;
                s_p2[idx] = bus.player2;
                s_win[idx] = bus.win_mask;
                s_put[idx] = bus.put_line;
                s_turn[idx] = bus.turn;
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_board_renderer.md
# vga_board_renderer

Parametrised VGA timing generator and game-board renderer for the Score4 display path. It produces sync and 12-bit RGB for a configurable grid of round-less square cells plus a "put line" selector row. Board state is snapshotted once per frame so the picture never tears. Winning cells blink. It sits between the game controller (board, turn, win state) and the VGA DAC pins.

## Interface
- `DIV`, 2: system clocks per pixel (≥1); the pixel enable fires once every `DIV` clocks.
- `H_ACTIVE`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal timing in pixels. `H_TOTAL` = sum = 800.
- `V_ACTIVE`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 32: vertical timing in lines. `V_TOTAL` = sum = 524.
- `ROWS`, 6 / `COLS`, 7: board dimensions.
- `CELL`, 30: cell edge in pixels. `PITCH`, 60: cell-to-cell pitch (> `CELL`).
- `X0`, 60 / `Y0`, 30: top-left pixel of cell (row 0, screen-column 0).
- `PUT_H`, 20: put-line bar height.
- `BLINK_FRAMES`, 30: frames per blink phase (≥1).
- `clk` in 1: system clock.
- `rst` in 1: reset. **Synchronous, active-low.**
- `turn` in 1: 0 = player 1 to move, 1 = player 2.
- `player1` in ROWS*COLS: occupancy of player 1. Bit `r*COLS+c`.
- `player2` in ROWS*COLS: occupancy of player 2. Same indexing.
- `win_mask` in ROWS*COLS: cells that blink.
- `put_line` in COLS: one-hot (or zero) selector column.
- `hsync` out 1: active-low horizontal sync.
- `vsync` out 1: active-low vertical sync.
- `red`, `green`, `blue` out 4 each: pixel colour.
- `frame_start` out 1: one-clock pulse when a new snapshot is taken.

## Operation
- **Divider:** `div_cnt` counts 0..DIV-1 and wraps. `pe` = (`div_cnt` == DIV-1).
- **Counters:** `h_cnt` and `v_cnt` advance only on `pe`.
  - `h_cnt` wraps H_TOTAL-1 → 0.
  - `v_cnt` increments on `h_cnt` wrap and wraps V_TOTAL-1 → 0.
- **Sync:**
  - `hsync` is low iff `h_cnt` ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - `vsync` is low iff `v_cnt` ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- **Snapshot:** on `pe` at `h_cnt`=H_TOTAL-1 and `v_cnt`=V_TOTAL-1, the block latches `player1`, `player2`, `win_mask`, `put_line` and `turn` into shadow registers. Only shadow values are rendered. Input changes mid-frame are invisible until the next frame.
- **Blink:** the frame counter increments at each snapshot. When it reaches BLINK_FRAMES-1 it wraps to 0 and `blink` toggles.
- **Cell hit:**
  - Screen-column k hits when x ∈ [X0+k·PITCH, X0+k·PITCH+CELL-1].
  - Row r hits when y ∈ [Y0+r·PITCH, Y0+r·PITCH+CELL-1].
  - Screen-column k maps to board column `COLS-1-k`, so the leftmost cell is the MSB column.
- **Put-line hit:** same column rule, with y ∈ [Y0+ROWS·PITCH, Y0+ROWS·PITCH+PUT_H-1].
- **Colour priority** (first match wins; R,G,B hex):
  1. Outside active area → 0,0,0.
  2. Cell with win bit set and `blink`=1 → F,F,F.
  3. Cell with player1 bit set → F,1,0. Player1 wins if both player bits are set.
  4. Cell with player2 bit set → 0,F,3.
  5. Empty cell → 2,2,2.
  6. Put-line hit on a set `put_line` bit: `turn`=0 → F,0,1; `turn`=1 → 0,F,3.
  7. Otherwise → 0,0,0.
- **Arithmetic:** hit decode uses unsigned compares wide enough for H_TOTAL/V_TOTAL. Geometry that falls beyond the active area is simply never hit and must not be an error.

## Timing
- **Pipeline:** two stages, both advancing on `pe`.
  - Stage 1 registers the hit, row and column decode.
  - Stage 2 registers the RGB colour plus `hsync`/`vsync`.
  - Outputs therefore lag the counters by exactly 2 pixel periods. Sync and colour stay mutually aligned.
  - Between `pe` pulses all outputs hold.
- **`frame_start`:** high for exactly one `clk`, the clock after the snapshot `pe`. It is never asserted during reset.
- **Reset** (`rst`=0 at a `clk` edge):
  - Cleared to 0: `div_cnt`, `h_cnt`, `v_cnt`, frame counter, `blink`, all shadow and pipeline registers.
  - Outputs: `hsync`=1, `vsync`=1, RGB=0, `frame_start`=0.
  - Reset mid-frame aborts the frame. After release, scanning restarts at (0,0), with the first `pe` DIV clocks later.
- **DIV=1:** `pe` is constantly high.
- **Frame period:** H_TOTAL·V_TOTAL·DIV clocks = 838,400 at defaults.

## Test plan
- **Reset, then run one frame at defaults:**
  - The first `frame_start` arrives 838,400 clocks after reset release.
  - `hsync` low for 96 pixels, starting at pixel 656 (plus 2-pixel latency).
  - `vsync` low on lines 490–491.
- **Player 1 occupies board (0,6):** pixel x=60, y=30 outputs F,1,0. x=59 outputs 0,0,0 and x=90 outputs 0,0,0.
- **Overlap and put-line:**
  - Same cell set in both player1 and player2 → F,1,0.
  - With `put_line`=7'b1000000 and `turn`=1, pixel x=60, y=390 → 0,F,3.
- **Tearing check:** change `player2` while line 100 is being scanned. The current frame is unchanged; the new value appears only after the next `frame_start`.
- **Blink:** `win_mask` bit set with BLINK_FRAMES=2.
  - The cell alternates between its player colour and F,F,F every 2 frames.
  - Deasserting `rst` mid-blink restarts with `blink`=0.
- **Non-default geometry:** DIV=1, ROWS=4, COLS=5. Verify 800×524-clock frames and the cell edge at x=X0+4·PITCH+CELL-1.
